// File: rtl/ehgu_sync_fifo.sv
// ehgu_sync_fifo: single-clock FIFO with level, full/empty/almost flags, flush,
// sticky overflow/underflow and a registered or first-word-fall-through read port.
module ehgu_sync_fifo #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int FWFT      = 0,
    parameter int AF_THRESH = 12,
    parameter int AE_THRESH = 2
) (
    input  logic                       clk0,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       rd_valid,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       overflow,
    output logic                       underflow
);
    localparam int LW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wptr, rptr;
    logic [WIDTH-1:0] rd_q;
    logic             rd_vq, rd_ok, wr_ok;

    // explicit wrap so non-power-of-two depths work
    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full         = level == LW'(DEPTH);
    assign empty        = level == '0;
    assign almost_full  = level >= LW'(AF_THRESH);
    assign almost_empty = level <= LW'(AE_THRESH);
    assign rd_ok        = rd_en & !empty & !flush;
    assign wr_ok        = wr_en & (!full | rd_ok) & !flush;
    assign rd_valid     = (FWFT != 0) ? !empty : rd_vq;
    assign rd_data      = (FWFT != 0) ? (empty ? '0 : mem[rptr]) : rd_q;

    always_ff @(posedge clk0)
        if (wr_ok) mem[wptr] <= wr_data;

    always_ff @(posedge clk0 or posedge rst) begin
        if (rst) begin
            wptr      <= '0;
            rptr      <= '0;
            level     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            rd_vq     <= 1'b0;
            rd_q      <= '0;
        end else if (flush) begin
            wptr      <= '0;
            rptr      <= '0;
            level     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            rd_vq     <= 1'b0;
        end else begin
            wptr      <= wr_ok ? inc(wptr) : wptr;
            rptr      <= rd_ok ? inc(rptr) : rptr;
            level     <= level + LW'(wr_ok) - LW'(rd_ok);
            overflow  <= overflow | (wr_en & !wr_ok);
            underflow <= underflow | (rd_en & !rd_ok);
            rd_vq     <= rd_ok;
            rd_q      <= rd_ok ? mem[rptr] : rd_q;
        end
    end
endmodule

// File: tb/tb_ehgu_sync_fifo.sv
// tb_ehgu_sync_fifo: table vectors, corner sequences and random traffic against a queue model,
// driving a registered-read and a FWFT instance in parallel.
module tb_ehgu_sync_fifo;
    localparam int W = 8, D = 5, LW = $clog2(D + 1);

    logic clk0 = 0, rst = 1, flush = 0, wr_en = 0, rd_en = 0;
    logic [W-1:0] wr_data = 0;
    logic [W-1:0] rdd [2];
    logic [LW-1:0] lvl [2];
    logic rdv [2], ful [2], emp [2], af [2], ae [2], ovf [2], unf [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        ehgu_sync_fifo #(.WIDTH(W), .DEPTH(D), .FWFT(g), .AF_THRESH(4), .AE_THRESH(1)) dut (
            .clk0(clk0), .rst(rst), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
            .rd_en(rd_en), .rd_data(rdd[g]), .rd_valid(rdv[g]), .full(ful[g]),
            .empty(emp[g]), .almost_full(af[g]), .almost_empty(ae[g]), .level(lvl[g]),
            .overflow(ovf[g]), .underflow(unf[g]));
    end

    always #5 clk0 = ~clk0;

    int checks = 0, errors = 0;
    logic [W-1:0] q [$];
    bit m_ovf, m_unf, m_vld;
    logic [W-1:0] m_data;

    typedef struct {
        bit f, w, r;
        logic [W-1:0] d;
        int lvl;
        bit vld;
        logic [W-1:0] dat;
        bit ovf, unf;
    } vec_t;
    vec_t tab [$];

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
        end
    endtask

    task automatic check_model();
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("level[%0d]", i), 32'(lvl[i]), q.size());
            chk($sformatf("full[%0d]", i), 32'(ful[i]), 32'(q.size() == D));
            chk($sformatf("empty[%0d]", i), 32'(emp[i]), 32'(q.size() == 0));
            chk($sformatf("almost_full[%0d]", i), 32'(af[i]), 32'(q.size() >= 4));
            chk($sformatf("almost_empty[%0d]", i), 32'(ae[i]), 32'(q.size() <= 1));
            chk($sformatf("overflow[%0d]", i), 32'(ovf[i]), 32'(m_ovf));
            chk($sformatf("underflow[%0d]", i), 32'(unf[i]), 32'(m_unf));
        end
        chk("rd_valid[0]", 32'(rdv[0]), 32'(m_vld));
        chk("rd_data[0]", 32'(rdd[0]), 32'(m_data));
        chk("rd_valid[1]", 32'(rdv[1]), 32'(q.size() != 0));
        if (q.size() != 0) chk("rd_data[1]", 32'(rdd[1]), 32'(q[0]));
    endtask

    task automatic step(input bit f, input bit w, input bit r, input logic [W-1:0] d);
        bit rok, wok;
        flush = f; wr_en = w; rd_en = r; wr_data = d;
        @(posedge clk0);
        if (f) begin
            q.delete();
            m_ovf = 0; m_unf = 0; m_vld = 0;
        end else begin
            rok = r && q.size() > 0;
            wok = w && (q.size() < D || rok);
            m_vld = rok;
            if (rok) m_data = q.pop_front();
            if (wok) q.push_back(d);
            if (w && !wok) m_ovf = 1;
            if (r && !rok) m_unf = 1;
        end
        #1;
        check_model();
    endtask

    task automatic add(input bit f, input bit w, input bit r, input logic [W-1:0] d,
                       input int l, input bit v, input logic [W-1:0] dt, input bit o, input bit u);
        tab.push_back('{f: f, w: w, r: r, d: d, lvl: l, vld: v, dat: dt, ovf: o, unf: u});
    endtask

    task automatic check_reset();
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("rst level[%0d]", i), 32'(lvl[i]), 0);
            chk($sformatf("rst empty[%0d]", i), 32'(emp[i]), 1);
            chk($sformatf("rst full[%0d]", i), 32'(ful[i]), 0);
            chk($sformatf("rst almost_empty[%0d]", i), 32'(ae[i]), 1);
            chk($sformatf("rst almost_full[%0d]", i), 32'(af[i]), 0);
            chk($sformatf("rst rd_valid[%0d]", i), 32'(rdv[i]), 0);
            chk($sformatf("rst overflow[%0d]", i), 32'(ovf[i]), 0);
            chk($sformatf("rst underflow[%0d]", i), 32'(unf[i]), 0);
        end
        chk("rst rd_data[0]", 32'(rdd[0]), 0);
    endtask

    initial begin
        m_ovf = 0; m_unf = 0; m_vld = 0; m_data = 0;
        // fill, overflow, drain, underflow, flush
        add(0,1,0,8'h11, 1,0,8'h00,0,0); add(0,1,0,8'h12, 2,0,8'h00,0,0);
        add(0,1,0,8'h13, 3,0,8'h00,0,0); add(0,1,0,8'h14, 4,0,8'h00,0,0);
        add(0,1,0,8'h15, 5,0,8'h00,0,0); add(0,1,0,8'h99, 5,0,8'h00,1,0);
        add(0,0,1,8'h00, 4,1,8'h11,1,0); add(0,0,1,8'h00, 3,1,8'h12,1,0);
        add(0,0,1,8'h00, 2,1,8'h13,1,0); add(0,0,1,8'h00, 1,1,8'h14,1,0);
        add(0,0,1,8'h00, 0,1,8'h15,1,0); add(0,0,1,8'h00, 0,0,8'h15,1,1);
        add(1,0,0,8'h00, 0,0,8'h15,0,0);
        // simultaneous read/write at full, then at empty
        add(0,1,0,8'h01, 1,0,8'h15,0,0); add(0,1,0,8'h02, 2,0,8'h15,0,0);
        add(0,1,0,8'h03, 3,0,8'h15,0,0); add(0,1,0,8'h04, 4,0,8'h15,0,0);
        add(0,1,0,8'h05, 5,0,8'h15,0,0); add(0,1,1,8'h20, 5,1,8'h01,0,0);
        add(0,0,1,8'h00, 4,1,8'h02,0,0); add(0,0,1,8'h00, 3,1,8'h03,0,0);
        add(0,0,1,8'h00, 2,1,8'h04,0,0); add(0,0,1,8'h00, 1,1,8'h05,0,0);
        add(0,0,1,8'h00, 0,1,8'h20,0,0); add(0,1,1,8'h30, 1,0,8'h20,0,1);
        // flush with both requests at level 3 and overflow set
        add(0,1,0,8'h31, 2,0,8'h20,0,1); add(0,1,0,8'h32, 3,0,8'h20,0,1);
        add(0,1,0,8'h33, 4,0,8'h20,0,1); add(0,1,0,8'h34, 5,0,8'h20,0,1);
        add(0,1,0,8'h35, 5,0,8'h20,1,1); add(0,0,1,8'h00, 4,1,8'h30,1,1);
        add(0,0,1,8'h00, 3,1,8'h31,1,1); add(1,1,1,8'h77, 0,0,8'h31,0,0);

        repeat (2) @(posedge clk0);
        #1;
        check_reset();
        rst = 0;
        foreach (tab[k]) begin
            step(tab[k].f, tab[k].w, tab[k].r, tab[k].d);
            chk($sformatf("tab%0d level", k), 32'(lvl[0]), 32'(tab[k].lvl));
            chk($sformatf("tab%0d rd_valid", k), 32'(rdv[0]), 32'(tab[k].vld));
            chk($sformatf("tab%0d rd_data", k), 32'(rdd[0]), 32'(tab[k].dat));
            chk($sformatf("tab%0d overflow", k), 32'(ovf[0]), 32'(tab[k].ovf));
            chk($sformatf("tab%0d underflow", k), 32'(unf[0]), 32'(tab[k].unf));
        end

        // pointer wrap at steady level 3
        for (int i = 0; i < 3; i++) step(0, 1, 0, 8'(8'h40 + i));
        for (int i = 0; i < 12; i++) begin
            step(0, 1, 1, 8'(8'h50 + i));
            chk("wrap level", 32'(lvl[0]), 3);
        end

        // FWFT head visible without rd_en, gone after pop
        step(1, 0, 0, 8'h00);
        step(0, 1, 0, 8'hA5);
        chk("fwft valid", 32'(rdv[1]), 1);
        chk("fwft data", 32'(rdd[1]), 32'hA5);
        step(0, 0, 1, 8'h00);
        chk("fwft pop valid", 32'(rdv[1]), 0);

        for (int i = 0; i < 1500; i++) begin
            if (i == 700) begin
                rst = 1;
                #1;
                check_reset();
                q.delete();
                m_ovf = 0; m_unf = 0; m_vld = 0; m_data = 0;
                #2 rst = 0;
            end
            step($urandom_range(0, 49) == 0, ($urandom % 10) < 6, $urandom_range(0, 1) == 1,
                 8'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
